// File: rtl/dkong_video_pkg.sv
// Shared types and defaults for the Donkey Kong video RAM arbitration logic.
`timescale 1ns/1ps
package dkong_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } vram_state_t;

  localparam int MAX_WAIT_DEF = 16;

endpackage

// File: rtl/dkong_vram_arb.sv
// Single-port tile VRAM arbiter: the video fetch normally owns the port, and the CPU
// gets it in idle video slots or, once it has waited long enough, by forcing a video miss.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no CPU access in flight; grant CPU when video idle or starved
// ST_CAPTURE | RAM output for the granted CPU access is captured
// ST_HOLD    | cpu_ack high until the CPU drops cpu_req
`timescale 1ns/1ps
module dkong_vram_arb
  import dkong_video_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              vram_busy,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  output logic              vid_miss,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [7:0] WAIT_TC = 8'(MAX_WAIT - 1);

  vram_state_t state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        starved;
  logic        grant;

  assign starved = (wait_cnt == WAIT_TC);
  // Gating with rst_n keeps a write from reaching the RAM while reset is held.
  assign grant   = rst_n && (state == ST_IDLE) && cpu_req && (!vid_req || starved);

  assign ram_addr  = grant ? cpu_addr : vid_addr;
  assign ram_we    = grant && cpu_we;
  assign ram_wdata = cpu_wdata;
  assign vid_data  = ram_rdata;
  assign vid_miss  = grant && vid_req;
  assign cpu_ack   = (state == ST_HOLD);
  assign vram_busy = cpu_req && !cpu_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_HOLD;
      ST_HOLD:    if (!cpu_req) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      cpu_rdata <= 8'd0;
      vid_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      vid_valid <= vid_req && !grant;
      if (state == ST_CAPTURE) cpu_rdata <= ram_rdata;
      if (!cpu_req || grant) begin
        wait_cnt <= 8'd0;
      end else if (state == ST_IDLE && !starved) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dkong_vram_arb.sv
// Self-checking bench for dkong_vram_arb: registered RAM model plus a per-access
// reference computed from request timing and a shadow copy of VRAM contents.
`timescale 1ns/1ps
module tb_dkong_vram_arb;

  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata, cpu_rdata;
  logic              cpu_ack, vram_busy;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              vid_valid, vid_miss;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic       ram_init_done = 1'b0;

  always #5 clk = ~clk;

  dkong_vram_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .vram_busy(vram_busy),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_miss(vid_miss),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] seed_val(input int i);
    return 8'((i * 29 + 7) & 255);
  endfunction

  // Registered single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (!rst_n && !ram_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_val(i);
      ram_init_done <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic vid_pattern(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock cycle: drive video inputs, check combinational outputs mid-cycle,
  // then check the registered video result just after the edge.
  task automatic tick(input logic vreq, input logic [ADDR_W-1:0] vaddr,
                      input bit exp_grant, input bit exp_ack);
    logic       nv;
    logic [7:0] nd;
    vid_req  = vreq;
    vid_addr = vaddr;
    @(negedge clk);
    chk("ram_we", ram_we, exp_grant && cpu_we);
    chk("vid_miss", vid_miss, exp_grant && vreq);
    chk("ram_addr", ram_addr, exp_grant ? cpu_addr : vaddr);
    chk("cpu_ack", cpu_ack, exp_ack);
    chk("vram_busy", vram_busy, cpu_req && !exp_ack);
    if (exp_grant && cpu_we) chk("ram_wdata", ram_wdata, cpu_wdata);
    nv = vreq && !exp_grant;
    nd = ref_mem[vaddr];
    if (exp_grant && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    @(posedge clk);
    #1;
    chk("vid_valid", vid_valid, nv);
    if (nv) chk("vid_data", vid_data, nd);
  endtask

  // Full CPU access: grant lands on the first cycle with no video request, or when
  // the wait count reaches MAX_WAIT-1; ack two cycles later; held until req drops.
  task automatic access(input logic [ADDR_W-1:0] a, input logic w, input logic [7:0] d,
                        input int mode, input int hold);
    int         gcyc;
    logic [7:0] exp_rd;
    logic       vr;
    bit         g;
    gcyc = -1;
    exp_rd = 8'h00;
    cpu_addr = a; cpu_we = w; cpu_wdata = d; cpu_req = 1'b1;
    for (int k = 0; k < 64; k++) begin
      vr = vid_pattern(mode, k);
      g  = (gcyc < 0) && (!vr || k == MAX_WAIT - 1);
      if (g) begin
        gcyc = k;
        exp_rd = ref_mem[a];
      end
      if (gcyc >= 0 && k == gcyc + 3 + hold) cpu_req = 1'b0;
      tick(vr, 10'($urandom()), g, gcyc >= 0 && k >= gcyc + 2);
      if (gcyc >= 0 && k >= gcyc + 2 && !w) chk("cpu_rdata", cpu_rdata, exp_rd);
      if (!cpu_req) break;
    end
    if (cpu_req) begin
      chk("access_timeout", 32'(cpu_req), 32'd0);
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
    #1;
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_vid_valid", vid_valid, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_vid_miss", vid_miss, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 0x3C to 0x010 with video idle, then fetch it back on the video side.
    access(10'h010, 1'b1, 8'h3C, 0, 0);
    tick(1'b1, 10'h010, 1'b0, 1'b0);
    chk("vid_readback_010", vid_data, 8'h3C);

    // 0x155 holds 0xA5, then an uncontended read of it.
    access(10'h155, 1'b1, 8'hA5, 0, 0);
    access(10'h155, 1'b0, 8'h00, 0, 0);
    chk("rdata_155", cpu_rdata, 8'hA5);

    // Continuous video traffic forces a starvation override.
    access(10'h155, 1'b0, 8'h00, 1, 1);
    // Alternating video requests: CPU slips into the first gap.
    access(10'h010, 1'b0, 8'h00, 2, 0);
    // Request held five cycles after ack.
    access(10'h2AA, 1'b1, 8'h5A, 0, 5);

    // Reset while in CAPTURE.
    cpu_addr = 10'h155; cpu_we = 1'b0; cpu_wdata = 8'h00; cpu_req = 1'b1;
    tick(1'b0, 10'h000, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cpu_ack", cpu_ack, 1'b0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("mid_rst_vid_valid", vid_valid, 1'b0);
    cpu_we = 1'b1; cpu_wdata = 8'hEE; vid_req = 1'b1;
    #1;
    chk("mid_rst_ram_we", ram_we, 1'b0);
    chk("mid_rst_vid_miss", vid_miss, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_ack_low", cpu_ack, 1'b0);
      chk("mid_rst_we_low", ram_we, 1'b0);
    end
    cpu_req = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b1, 10'h155, 1'b0, 1'b0);
    chk("no_write_in_reset", vid_data, 8'hA5);

    // Randomized accesses with idle gaps between them.
    for (int t = 0; t < 40; t++) begin
      access(10'($urandom()), 1'($urandom_range(0, 1)), 8'($urandom()),
             $urandom_range(0, 3), $urandom_range(0, 3));
      for (int gap = $urandom_range(0, 2); gap > 0; gap--)
        tick(1'($urandom_range(0, 1)), 10'($urandom()), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
